// File: rtl/speed_select_ctrl_pkg.sv
// Shared speed-code definitions for the speed select stage and the rate divider.
package speed_pkg;

  typedef logic [1:0] speed_t;

  localparam speed_t SPEED_FASTEST = 2'd0;
  localparam speed_t SPEED_SLOWEST = 2'd3;

endpackage

// File: rtl/speed_select_ctrl_if.sv
// Button inputs and speed outputs of the speed select stage.
interface speed_select_ctrl_if;
  import speed_pkg::*;

  logic   KeyFaster;
  logic   KeySlower;
  speed_t Speed;
  logic   SpeedChanged;

  // Button source / speed consumer side.
  modport master (
    output KeyFaster,
    output KeySlower,
    input  Speed,
    input  SpeedChanged
  );

  // Speed select controller side.
  modport slave (
    input  KeyFaster,
    input  KeySlower,
    output Speed,
    output SpeedChanged
  );

endinterface

// File: rtl/speed_select_ctrl_key_debouncer.sv
// One raw pushbutton -> synchronised, debounced level plus a one-cycle press strobe.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic ClockIn,
  input  logic Reset,
  input  logic KeyRaw,
  output logic KeyLevel,
  output logic KeyPress
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_level_d;

  // Two-flop synchroniser for the asynchronous button input.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= KeyRaw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt   <= '0;
      r_level <= ~r_level;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Delayed level for rising-edge detection; releases are ignored.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_level_d <= 1'b0;
    end else begin
      r_level_d <= r_level;
    end
  end

  assign KeyLevel = r_level;
  assign KeyPress = r_level & ~r_level_d;

endmodule

// File: rtl/speed_select_ctrl.sv
// Turns faster/slower buttons into a saturating 2-bit speed code with a change pulse.
module speed_select_ctrl
  import speed_pkg::*;
#(
  parameter int     DEBOUNCE_CYCLES = 4,
  parameter speed_t SPEED_RESET     = 2'd3
) (
  input  logic                ClockIn,
  input  logic                Reset,
  speed_select_ctrl_if.slave  bus
);

  logic   w_fast_press;
  logic   w_slow_press;
  speed_t w_speed_next;
  logic   w_update;
  speed_t r_speed;
  logic   r_changed;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fast (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .KeyRaw   (bus.KeyFaster),
    .KeyLevel (),
    .KeyPress (w_fast_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_slow (
    .ClockIn  (ClockIn),
    .Reset    (Reset),
    .KeyRaw   (bus.KeySlower),
    .KeyLevel (),
    .KeyPress (w_slow_press)
  );

  // Arbitrate presses; simultaneous presses cancel, saturation checked before stepping.
  always_comb begin
    w_speed_next = r_speed;
    w_update     = 1'b0;
    if (w_fast_press && !w_slow_press) begin
      if (r_speed != SPEED_FASTEST) begin
        w_speed_next = r_speed - 2'd1;
        w_update     = 1'b1;
      end
    end else if (w_slow_press && !w_fast_press) begin
      if (r_speed != SPEED_SLOWEST) begin
        w_speed_next = r_speed + 2'd1;
        w_update     = 1'b1;
      end
    end
  end

  // Speed register and its one-cycle change pulse.
  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      r_speed   <= SPEED_RESET;
      r_changed <= 1'b0;
    end else begin
      r_speed   <= w_speed_next;
      r_changed <= w_update;
    end
  end

  assign bus.Speed        = r_speed;
  assign bus.SpeedChanged = r_changed;

endmodule

// File: tb/tb_speed_select_ctrl.sv
// Directed bench for speed_select_ctrl (DEBOUNCE_CYCLES=4, SPEED_RESET=3).
module tb_speed_select_ctrl;
  import speed_pkg::*;

  typedef struct {
    logic   fast;
    logic   slow;
    speed_t exp_speed;
    logic   exp_pulse;
  } vec_t;

  logic ClockIn = 1'b0;
  logic Reset   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  speed_select_ctrl_if bus ();

  speed_select_ctrl #(.DEBOUNCE_CYCLES(4), .SPEED_RESET(2'd3)) dut (
    .ClockIn (ClockIn),
    .Reset   (Reset),
    .bus     (bus)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ClockIn);
    #1;
  endtask

  task automatic set_keys(input logic f, input logic s);
    @(negedge ClockIn);
    bus.KeyFaster = f;
    bus.KeySlower = s;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic async_reset();
    @(negedge ClockIn);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_reset_speed", int'(bus.Speed), 3);
    chk("async_reset_pulse", int'(bus.SpeedChanged), 0);
    @(negedge ClockIn);
    Reset = 1'b0;
  endtask

  vec_t   vecs [10];
  speed_t prev;

  initial begin
    bus.KeyFaster = 1'b0;
    bus.KeySlower = 1'b0;

    // 1: reset takes effect without a clock edge, stays put when idle.
    #1 Reset = 1'b1;
    #2;
    chk("reset_speed", int'(bus.Speed), 3);
    chk("reset_pulse", int'(bus.SpeedChanged), 0);
    @(negedge ClockIn);
    Reset = 1'b0;
    idle(20);
    chk("idle_speed", int'(bus.Speed), 3);
    chk("idle_pulse", int'(bus.SpeedChanged), 0);
    $display("t1 reset/idle speed=%0d", bus.Speed);

    // 2: held faster key -> one step at edge 7, pulse one cycle only.
    set_keys(1'b1, 1'b0);
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 6) chk("hold_e6_speed", int'(bus.Speed), 3);
      if (e == 7) begin
        chk("hold_e7_speed", int'(bus.Speed), 2);
        chk("hold_e7_pulse", int'(bus.SpeedChanged), 1);
      end
      if (e == 8) chk("hold_e8_pulse", int'(bus.SpeedChanged), 0);
      if (e == 10) chk("hold_e10_speed", int'(bus.Speed), 2);
    end
    set_keys(1'b0, 1'b0);
    idle(12);
    chk("release_speed", int'(bus.Speed), 2);
    $display("t2 held press speed=%0d", bus.Speed);

    // 3: bounce 1,0,1,1,0 then steady 1 -> single decrement at edge 12.
    begin
      logic [4:0] pat;
      pat = 5'b10110;
      for (int e = 1; e <= 13; e++) begin
        if (e <= 5) set_keys(pat[5-e], 1'b0);
        else if (e == 6) set_keys(1'b1, 1'b0);
        tick();
        if (e == 11) chk("bounce_e11_speed", int'(bus.Speed), 2);
        if (e == 12) begin
          chk("bounce_e12_speed", int'(bus.Speed), 1);
          chk("bounce_e12_pulse", int'(bus.SpeedChanged), 1);
        end
        if (e == 13) chk("bounce_e13_pulse", int'(bus.SpeedChanged), 0);
      end
      set_keys(1'b0, 1'b0);
      idle(12);
      $display("t3 bounce speed=%0d", bus.Speed);
    end

    // 4/5: clean presses from 3, saturation both ends, simultaneous presses.
    async_reset();
    vecs[0] = '{1'b1, 1'b0, 2'd2, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'd0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 2'd1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 2'd2, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 2'd3, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 2'd3, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 2'd2, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 2'd2, 1'b0};
    prev = 2'd3;
    for (int v = 0; v < 10; v++) begin
      set_keys(vecs[v].fast, vecs[v].slow);
      idle(6);
      chk($sformatf("vec%0d_e6_speed", v), int'(bus.Speed), int'(prev));
      tick();
      chk($sformatf("vec%0d_speed", v), int'(bus.Speed), int'(vecs[v].exp_speed));
      chk($sformatf("vec%0d_pulse", v), int'(bus.SpeedChanged), int'(vecs[v].exp_pulse));
      tick();
      chk($sformatf("vec%0d_pulse_end", v), int'(bus.SpeedChanged), 0);
      set_keys(1'b0, 1'b0);
      idle(10);
      prev = vecs[v].exp_speed;
      $display("vec %0d fast=%0b slow=%0b speed=%0d pulse_exp=%0b",
               v, vecs[v].fast, vecs[v].slow, bus.Speed, vecs[v].exp_pulse);
    end

    // 6: reset mid-debounce, key still held afterwards -> new press 7 edges later.
    set_keys(1'b1, 1'b0);
    idle(4);
    #2;
    Reset = 1'b1;
    #1;
    chk("mid_reset_speed", int'(bus.Speed), 3);
    chk("mid_reset_pulse", int'(bus.SpeedChanged), 0);
    @(negedge ClockIn);
    Reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 6) chk("post_reset_e6_speed", int'(bus.Speed), 3);
      if (e == 7) begin
        chk("post_reset_e7_speed", int'(bus.Speed), 2);
        chk("post_reset_e7_pulse", int'(bus.SpeedChanged), 1);
      end
      if (e == 8) chk("post_reset_e8_pulse", int'(bus.SpeedChanged), 0);
    end
    set_keys(1'b0, 1'b0);
    idle(10);
    $display("t6 reset mid-debounce speed=%0d", bus.Speed);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
